// File: rtl/lsu_pkg.sv
// Shared types for the lsu_mem64 load/store unit: FSM state encoding,
// RV64 funct3 size/sign codes and the access-size helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_MERGE,
        S_WRITE,
        S_DONE,
        S_ERR
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access width in bytes; funct3[1:0] alone encodes the size.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        logic [3:0] sz;
        case (funct3[1:0])
            2'b00:   sz = 4'd1;
            2'b01:   sz = 4'd2;
            2'b10:   sz = 4'd4;
            default: sz = 4'd8;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational lane select and sign/zero extension of a 64-bit memory line
// into an RV64 load result.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] line_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] result_o
);

    logic [63:0] shifted;

    assign shifted = line_i >> {off_i, 3'b000};

    // NOTE: result_o gets a default before the case so no latch is inferred.
    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_B:    result_o = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    result_o = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    result_o = {{32{shifted[31]}}, shifted[31:0]};
            F3_D:    result_o = shifted;
            F3_BU:   result_o = {56'd0, shifted[7:0]};
            F3_HU:   result_o = {48'd0, shifted[15:0]};
            F3_WU:   result_o = {32'd0, shifted[31:0]};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem64.sv
// Multicycle RV64 load/store unit over a doubleword memory with fixed read
// latency. Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses.
module lsu_mem64
    import lsu_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        write_en,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [63:0] rdata,
    output logic        misalign_err,
    output logic [63:0] mem_addr,
    output logic        mem_wr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [2:0]  off_q, off_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] line_q, line_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]  size_in;
    logic [2:0]  low_mask;
    logic [2:0]  off_in;
    logic        fault;
    logic [63:0] load_res;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    assign size_in  = size_bytes(funct3);
    assign low_mask = size_in[2:0] - 3'd1;
    // Naturally aligned lane offset; with the trap enabled it equals addr[2:0]
    // whenever the access is allowed to proceed.
    assign off_in   = addr[2:0] & ~low_mask;

`ifdef LSU_MISALIGN_TRAP_EN
    assign fault = (funct3 == 3'b111) || (write_en && funct3[2]) ||
                   (|(addr[2:0] & low_mask));
`else
    assign fault = (funct3 == 3'b111) || (write_en && funct3[2]);
`endif

    lsu_load_align u_align (
        .line_i   (mem_rdata),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .result_o (load_res)
    );

    always_comb begin
        lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (f3_q[1:0])
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane_mask = lane_mask << {off_q, 3'b000};
        merged    = (line_q & ~lane_mask) | ((wdata_q << {off_q, 3'b000}) & lane_mask);
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        line_d      = line_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d       = write_en;
                    f3_d       = funct3;
                    off_d      = off_in;
                    wdata_d    = wdata;
                    mem_addr_d = {addr[63:3], 3'b000};
                    cnt_d      = CW'(MEM_LAT - 1);
                    if (fault) begin
                        state_d = S_ERR;
                    end else if (write_en && size_in == 4'd8) begin
                        mem_wdata_d = wdata;
                        state_d     = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                if (cnt_q == '0) begin
                    line_d = mem_rdata;
                    if (we_q) begin
                        state_d = S_MERGE;
                    end else begin
                        rdata_d = load_res;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_MERGE: begin
                mem_wdata_d = merged;
                state_d     = S_WRITE;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            line_q      <= line_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
        end
    end

    // Strobes decode straight from state so reset removes them immediately.
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE) || (state_q == S_ERR);
    assign misalign_err = (state_q == S_ERR);
    assign mem_wr       = (state_q == S_WRITE);
    assign rdata        = rdata_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

endmodule
